seg7_axil_slave: RTL and testbench

AXI4-Lite responder for the 7-segment display peripheral: accepts single-beat writes and reads from the PS/VIP master into four 32-bit registers, and drives a 4-digit multiplexed common-anode 7-segment display from their contents. It sits behind the AXI interconnect as slave S00_AXI and owns the board display pins.

---
 rtl/seg7_axil_slave_if.sv | 43 ++++
 rtl/seg7_axil_slave.sv | 248 ++++++++++++++++++++++++
 tb/tb_seg7_axil_slave.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_axil_slave_if.sv
// AXI4-Lite bus bundle between the interconnect master and the 7-segment
// display peripheral. Master drives requests, slave drives ready/response.
interface seg7_axil_slave_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  // Write address channel
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  // Write data channel
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  // Write response channel
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  // Read address channel
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  // Read data channel
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/seg7_axil_slave.sv
// AXI4-Lite slave holding four 32-bit registers and driving a 4-digit
// multiplexed common-anode 7-segment display from them.
//   REG0: hex digit nibbles, REG1: [0] enable, [7:4] dp mask,
//   REG2: [15:0] scan divider, REG3: scratch.
module seg7_axil_slave #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [15:0] SCAN_DIV_RESET     = 16'd50000
) (
  input  logic       ACLK,
  input  logic       ARESET,
  seg7_axil_slave_if.slave s_axi,
  output logic [3:0] SEG_AN,
  output logic [6:0] SEG_CA,
  output logic       SEG_DP
);

  localparam int DW        = C_S_AXI_DATA_WIDTH;
  localparam int NUM_BYTES = DW / 8;
  localparam int NUM_REGS  = 4;
  localparam int SEL_MSB   = C_S_AXI_ADDR_WIDTH - 1;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;

  w_state_t        w_state_reg;
  r_state_t        r_state_reg;
  logic            awready_reg;
  logic            wready_reg;
  logic            bvalid_reg;
  logic            arready_reg;
  logic            rvalid_reg;
  logic [DW-1:0]   rdata_reg;

  logic [DW-1:0]   regs_reg [NUM_REGS];
  logic [DW-1:0]   wmask;
  logic [1:0]      wr_sel;
  logic [1:0]      rd_sel;
  logic            wr_en;

  logic [15:0]     prescaler_reg;
  logic [1:0]      digit_idx_reg;
  logic [15:0]     scan_div;
  logic            display_en;
  logic [3:0]      dp_mask;
  logic [3:0]      digit_val [NUM_REGS];

  logic [3:0]      seg_an_reg;
  logic [6:0]      seg_ca_reg;
  logic            seg_dp_reg;
  logic [3:0]      seg_an_next;
  logic [6:0]      seg_ca_next;
  logic            seg_dp_next;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic            unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                         s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  // Word select comes from the top two address bits.
  assign wr_sel = s_axi.awaddr[SEL_MSB -: 2];
  assign rd_sel = s_axi.araddr[SEL_MSB -: 2];

  // The addressed register is written on the edge that closes the AW/W
  // handshake, which is the edge leaving W_ACK.
  assign wr_en = (w_state_reg == W_ACK);

  // Expand byte strobes into a bit mask so untouched lanes keep their value.
  genvar gi;
  for (gi = 0; gi < NUM_BYTES; gi++) begin : g_wmask
    assign wmask[8*gi +: 8] = {8{s_axi.wstrb[gi]}};
  end

  // Split REG0 into the four displayed nibbles.
  for (gi = 0; gi < NUM_REGS; gi++) begin : g_digits
    assign digit_val[gi] = regs_reg[0][4*gi +: 4];
  end

  assign scan_div   = regs_reg[2][15:0];
  assign display_en = regs_reg[1][0];
  assign dp_mask    = regs_reg[1][7:4];

  // Standard hex font, active-high segments with bit0 = a .. bit6 = g.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Write channel FSM: both AW and W must be present before either ready is
  // raised, so a lone address or data beat simply waits.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_reg <= W_IDLE;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (s_axi.awvalid && s_axi.wvalid && !bvalid_reg) begin
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
            w_state_reg <= W_ACK;
          end
        end
        W_ACK: begin
          awready_reg <= 1'b0;
          wready_reg  <= 1'b0;
          bvalid_reg  <= 1'b1;
          w_state_reg <= W_RESP;
        end
        W_RESP: begin
          if (s_axi.bready) begin
            bvalid_reg  <= 1'b0;
            w_state_reg <= W_IDLE;
          end
        end
        default: begin
          awready_reg <= 1'b0;
          wready_reg  <= 1'b0;
          bvalid_reg  <= 1'b0;
          w_state_reg <= W_IDLE;
        end
      endcase
    end
  end

  // Read channel FSM: read data is captured on the AR handshake edge and
  // held until the master accepts it.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state_reg <= R_IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (s_axi.arvalid && !rvalid_reg) begin
            arready_reg <= 1'b1;
            r_state_reg <= R_ACK;
          end
        end
        R_ACK: begin
          arready_reg <= 1'b0;
          rvalid_reg  <= 1'b1;
          rdata_reg   <= regs_reg[rd_sel];
          r_state_reg <= R_DATA;
        end
        R_DATA: begin
          if (s_axi.rready) begin
            rvalid_reg  <= 1'b0;
            r_state_reg <= R_IDLE;
          end
        end
        default: begin
          arready_reg <= 1'b0;
          rvalid_reg  <= 1'b0;
          r_state_reg <= R_IDLE;
        end
      endcase
    end
  end

  // Register file with per-byte write enables; a read on the same edge
  // sees the pre-write contents.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      regs_reg[0] <= '0;
      regs_reg[1] <= '0;
      regs_reg[2] <= DW'(SCAN_DIV_RESET);
      regs_reg[3] <= '0;
    end else if (wr_en) begin
      regs_reg[wr_sel] <= (regs_reg[wr_sel] & ~wmask) | (s_axi.wdata & wmask);
    end
  end

  // Scan prescaler and digit index. Comparing with >= lets a freshly
  // lowered divider below the running count clear it on the next cycle.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      prescaler_reg <= '0;
      digit_idx_reg <= '0;
    end else if (prescaler_reg >= scan_div) begin
      prescaler_reg <= '0;
      digit_idx_reg <= digit_idx_reg + 2'd1;
    end else begin
      prescaler_reg <= prescaler_reg + 16'd1;
    end
  end

  // Pin values for the active digit; everything dark when disabled.
  always_comb begin
    seg_an_next = 4'hF;
    seg_ca_next = 7'h7F;
    seg_dp_next = 1'b1;
    if (display_en) begin
      seg_an_next = ~(4'b0001 << digit_idx_reg);
      seg_ca_next = ~hex7(digit_val[digit_idx_reg]);
      seg_dp_next = ~dp_mask[digit_idx_reg];
    end
  end

  // Register the display pins so they change glitch-free on the clock.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      seg_an_reg <= 4'hF;
      seg_ca_reg <= 7'h7F;
      seg_dp_reg <= 1'b1;
    end else begin
      seg_an_reg <= seg_an_next;
      seg_ca_reg <= seg_ca_next;
      seg_dp_reg <= seg_dp_next;
    end
  end

  assign s_axi.awready = awready_reg;
  assign s_axi.wready  = wready_reg;
  assign s_axi.bvalid  = bvalid_reg;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.arready = arready_reg;
  assign s_axi.rvalid  = rvalid_reg;
  assign s_axi.rdata   = rdata_reg;
  assign s_axi.rresp   = 2'b00;

  assign SEG_AN = seg_an_reg;
  assign SEG_CA = seg_ca_reg;
  assign SEG_DP = seg_dp_reg;

endmodule

// File: tb/tb_seg7_axil_slave.sv
// Self-checking bench for seg7_axil_slave: AXI register access, byte strobes,
// channel skew/backpressure, display scanning, disable and reset.
module tb_seg7_axil_slave;

  localparam int LIM = 60;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] seg_an;
  logic [6:0] seg_ca;
  logic       seg_dp;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];

  seg7_axil_slave_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

  seg7_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .SCAN_DIV_RESET(16'd50000)
  ) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .s_axi  (bus),
    .SEG_AN (seg_an),
    .SEG_CA (seg_ca),
    .SEG_DP (seg_dp)
  );

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(negedge clk);
    bus.awaddr  = addr;
    bus.awvalid = 1'b1;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.wvalid  = 1'b1;
    n = 0;
    while (!(bus.awready && bus.wready) && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check("wr_ready", 32'(bus.awready & bus.wready), 32'd1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check("wr_bvalid", 32'(bus.bvalid), 32'd1);
    check("wr_bresp", 32'(bus.bresp), 32'd0);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("wr_bvalid_clr", 32'(bus.bvalid), 32'd0);
    $display("WR addr=0x%h data=0x%08h strb=%b", addr, data, strb);
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp);
    int n;
    logic [31:0] e;
    logic [31:0] got;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check("rd_arready", 32'(bus.arready), 32'd1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("rd_rvalid", 32'(bus.rvalid), 32'd1);
    check("rd_rresp", 32'(bus.rresp), 32'd0);
    got = bus.rdata;
    e = exp_q.pop_front();
    check("rd_data", got, e);
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    check("rd_rvalid_clr", 32'(bus.rvalid), 32'd0);
    $display("RD addr=0x%h data=0x%08h expected=0x%08h", addr, got, e);
  endtask

  // Wait for the anode pattern to switch into 'target'; bounded.
  task automatic sync_an(input logic [3:0] target, input string tag);
    int n;
    logic [3:0] prev_an;
    prev_an = seg_an;
    @(negedge clk);
    n = 0;
    while (!(seg_an == target && prev_an != target) && n < LIM) begin
      prev_an = seg_an;
      @(negedge clk);
      n++;
    end
    check(tag, 32'(seg_an), 32'(target));
  endtask

  initial begin
    logic [3:0] an_tab [4];
    logic [6:0] ca_tab [4];
    logic       dp_tab [4];
    int n;

    an_tab = '{4'hE, 4'hD, 4'hB, 4'h7};
    ca_tab = '{7'h79, 7'h0E, 7'h30, 7'h08};
    dp_tab = '{1'b1, 1'b0, 1'b1, 1'b1};

    rst = 1'b1;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_awready", 32'(bus.awready), 32'd0);
    check("rst_wready", 32'(bus.wready), 32'd0);
    check("rst_arready", 32'(bus.arready), 32'd0);
    check("rst_bvalid", 32'(bus.bvalid), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_seg_an", 32'(seg_an), 32'hF);
    check("rst_seg_ca", 32'(seg_ca), 32'h7F);
    check("rst_seg_dp", 32'(seg_dp), 32'd1);
    rst = 1'b0;

    // Sequential write then read-back, plus low address bits ignored
    axi_write(4'h0, 32'd1, 4'hF);
    axi_write(4'h4, 32'd2, 4'hF);
    axi_write(4'h8, 32'd3, 4'hF);
    axi_write(4'hC, 32'd4, 4'hF);
    axi_read(4'h0, 32'd1);
    axi_read(4'h4, 32'd2);
    axi_read(4'h8, 32'd3);
    axi_read(4'hC, 32'd4);
    axi_read(4'h6, 32'd2);

    // Byte strobes
    axi_write(4'hC, 32'hAABBCCDD, 4'hF);
    axi_write(4'hC, 32'h11223344, 4'b0101);
    axi_read(4'hC, 32'hAA22CC44);

    // Channel skew: AW alone for 5 cycles, then long B backpressure
    @(negedge clk);
    bus.awaddr  = 4'hC;
    bus.awvalid = 1'b1;
    bus.wdata   = 32'h5A5A1234;
    bus.wstrb   = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("skew_no_ready", 32'({bus.awready, bus.wready}), 32'd0);
    end
    bus.wvalid = 1'b1;
    n = 0;
    while (!(bus.awready && bus.wready) && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check("skew_ready", 32'(bus.awready & bus.wready), 32'd1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("bp_bvalid_hold", 32'(bus.bvalid), 32'd1);
      @(negedge clk);
    end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("bp_bvalid_clr", 32'(bus.bvalid), 32'd0);
    $display("WR addr=0xc data=0x5a5a1234 strb=1111 (skewed, backpressured)");
    axi_read(4'hC, 32'h5A5A1234);

    // Display scan with divider 2
    axi_write(4'h0, 32'h0000A3F1, 4'hF);
    axi_write(4'h4, 32'h00000021, 4'hF);
    axi_write(4'h8, 32'h00000002, 4'hF);
    sync_an(4'hE, "scan_sync");
    for (int d = 0; d < 5; d++) begin
      for (int c = 0; c < 3; c++) begin
        check("scan_an", 32'(seg_an), 32'(an_tab[d % 4]));
        check("scan_ca", 32'(seg_ca), 32'(ca_tab[d % 4]));
        check("scan_dp", 32'(seg_dp), 32'(dp_tab[d % 4]));
        @(negedge clk);
      end
      $display("SCAN digit=%0d an=0x%h ca=0x%h", d % 4, an_tab[d % 4], ca_tab[d % 4]);
    end

    // Divider 0: index advances every cycle
    axi_write(4'h4, 32'h00000001, 4'hF);
    axi_write(4'h8, 32'h00000000, 4'hF);
    sync_an(4'hE, "div0_sync");
    check("div0_dp", 32'(seg_dp), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("div0_an", 32'(seg_an), 32'(an_tab[i % 4]));
    end
    $display("SCAN divider=0 stepping checked");

    // Disable
    axi_write(4'h4, 32'h00000000, 4'hF);
    @(negedge clk);
    check("dis_an", 32'(seg_an), 32'hF);
    check("dis_ca", 32'(seg_ca), 32'h7F);
    check("dis_dp", 32'(seg_dp), 32'd1);

    // Reset while a read response is pending
    axi_write(4'h8, 32'h00001234, 4'hF);
    @(negedge clk);
    bus.araddr  = 4'h8;
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check("rstrd_arready", 32'(bus.arready), 32'd1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("rstrd_rvalid", 32'(bus.rvalid), 32'd1);
    check("rstrd_rdata", bus.rdata, 32'h00001234);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstrd_rvalid_drop", 32'(bus.rvalid), 32'd0);
    check("rstrd_bvalid", 32'(bus.bvalid), 32'd0);
    $display("RST applied with read response pending");
    axi_read(4'h8, 32'h0000C350);
    axi_read(4'h0, 32'h00000000);
    axi_read(4'hC, 32'h00000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case the stimulus itself gets stuck.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
